// File: rtl/superscalar_pkg.sv
// Shared definitions for the dual-issue front end: RV32 opcodes used by the
// pair hazard decode, the issue FSM state type and small decode helpers.
package superscalar_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // PAIR: normal dual issue. SECOND: instr1 of a split pair still pending.
  typedef enum logic {
    PAIR   = 1'b0,
    SECOND = 1'b1
  } issue_state_t;

  // Writes a register: stores and branches have no rd, and x0 is never written.
  function automatic logic is_rd_wr(input logic [31:0] instr);
    logic [6:0] opc;
    opc = instr[6:0];
    return (opc != OPC_STORE) && (opc != OPC_BRANCH) && (instr[11:7] != 5'd0);
  endfunction

  // Reads rs1: everything except the upper-immediate and jal forms.
  function automatic logic uses_rs1(input logic [31:0] instr);
    logic [6:0] opc;
    opc = instr[6:0];
    return (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL);
  endfunction

  // Reads rs2: register-register ALU ops, stores and branches.
  function automatic logic uses_rs2(input logic [31:0] instr);
    logic [6:0] opc;
    opc = instr[6:0];
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  // Changes control flow.
  function automatic logic is_ctrl(input logic [31:0] instr);
    logic [6:0] opc;
    opc = instr[6:0];
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

  // Touches data memory.
  function automatic logic is_mem(input logic [31:0] instr);
    logic [6:0] opc;
    opc = instr[6:0];
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational check deciding whether an instruction pair must be issued
// one at a time. An empty (all-zero) slot never forces a split.
module pair_hazard_check
  import superscalar_pkg::*;
(
  input  logic [31:0] instr0,
  input  logic [31:0] instr1,
  output logic        split
);

  logic [4:0] rd0;
  logic [4:0] rd1;
  logic [4:0] rs1_1;
  logic [4:0] rs2_1;
  logic       both_present;
  logic       ctrl_hit;
  logic       mem_hit;
  logic       raw1_hit;
  logic       raw2_hit;
  logic       waw_hit;

  assign rd0   = instr0[11:7];
  assign rd1   = instr1[11:7];
  assign rs1_1 = instr1[19:15];
  assign rs2_1 = instr1[24:20];

  // Evaluate each hazard class separately so they are easy to observe.
  always_comb begin
    both_present = (instr0 != 32'd0) && (instr1 != 32'd0);
    ctrl_hit     = is_ctrl(instr0) || is_ctrl(instr1);
    mem_hit      = is_mem(instr0) && is_mem(instr1);
    raw1_hit     = is_rd_wr(instr0) && uses_rs1(instr1) && (rs1_1 == rd0);
    raw2_hit     = is_rd_wr(instr0) && uses_rs2(instr1) && (rs2_1 == rd0);
    waw_hit      = is_rd_wr(instr0) && is_rd_wr(instr1) && (rd1 == rd0);
    split        = both_present && (ctrl_hit || mem_hit || raw1_hit || raw2_hit || waw_hit);
  end

endmodule

// File: rtl/issue_split_dual.sv
// Dual-issue splitter between the IF/ID register and the ID/EX issue latches.
// A hazardous pair issues instr0 first while IF/ID is held, then instr1 alone.
//
// Handshake: fetch_we is the only flow-control signal towards IF/ID. When it
// is high at a rising edge the pair on pcD/instr0D/instr1D has been consumed
// and IF/ID may load the next pair; when low, IF/ID must hold its contents.
// ex_stall from downstream freezes the issue latches and state; flush clears
// them and dominates ex_stall.
module issue_split_dual
  import superscalar_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pcD,
  input  logic [31:0]      instr0D,
  input  logic [31:0]      instr1D,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             fetch_we,
  output logic             slot0_valid,
  output logic             slot1_valid,
  output logic [XLEN-1:0]  slot0_pc,
  output logic [XLEN-1:0]  slot1_pc,
  output logic [31:0]      slot0_instr,
  output logic [31:0]      slot1_instr,
  output issue_state_t     dbg_state
);

  issue_state_t    state_q, state_d;
  logic            s0_valid_q, s0_valid_d;
  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] s0_pc_q, s0_pc_d;
  logic [XLEN-1:0] s1_pc_q, s1_pc_d;
  logic [31:0]     s0_instr_q, s0_instr_d;
  logic [31:0]     s1_instr_q, s1_instr_d;

  logic            split;
  logic [XLEN-1:0] pc_plus4;

  // Wraps modulo 2^XLEN by construction.
  assign pc_plus4 = pcD + XLEN'(4);

  pair_hazard_check u_hazard (
    .instr0 (instr0D),
    .instr1 (instr1D),
    .split  (split)
  );

  // IF/ID write enable: low in reset, high on flush so IF/ID applies its own
  // flush, low while stalled, otherwise low only in the first cycle of a split.
  always_comb begin
    fetch_we = 1'b0;
    if (!rst_n) begin
      fetch_we = 1'b0;
    end else if (flush) begin
      fetch_we = 1'b1;
    end else if (ex_stall) begin
      fetch_we = 1'b0;
    end else if (state_q == SECOND) begin
      fetch_we = 1'b1;
    end else begin
      fetch_we = !split;
    end
  end

  // Next-state and issue-latch contents.
  always_comb begin
    state_d    = state_q;
    s0_valid_d = s0_valid_q;
    s1_valid_d = s1_valid_q;
    s0_pc_d    = s0_pc_q;
    s1_pc_d    = s1_pc_q;
    s0_instr_d = s0_instr_q;
    s1_instr_d = s1_instr_q;

    if (flush) begin
      state_d    = PAIR;
      s0_valid_d = 1'b0;
      s1_valid_d = 1'b0;
      s0_pc_d    = '0;
      s1_pc_d    = '0;
      s0_instr_d = 32'd0;
      s1_instr_d = 32'd0;
    end else if (!ex_stall) begin
      case (state_q)
        PAIR: begin
          s0_pc_d    = pcD;
          s0_instr_d = instr0D;
          if (split) begin
            s0_valid_d = 1'b1;
            s1_valid_d = 1'b0;
            s1_pc_d    = '0;
            s1_instr_d = 32'd0;
            state_d    = SECOND;
          end else begin
            s0_valid_d = (instr0D != 32'd0);
            s1_valid_d = (instr1D != 32'd0);
            s1_pc_d    = pc_plus4;
            s1_instr_d = instr1D;
            state_d    = PAIR;
          end
        end
        SECOND: begin
          s0_valid_d = (instr1D != 32'd0);
          s0_pc_d    = pc_plus4;
          s0_instr_d = instr1D;
          s1_valid_d = 1'b0;
          s1_pc_d    = '0;
          s1_instr_d = 32'd0;
          state_d    = PAIR;
        end
        default: begin
          state_d = PAIR;
        end
      endcase
    end
  end

  // State and issue latches; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PAIR;
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s0_pc_q    <= '0;
      s1_pc_q    <= '0;
      s0_instr_q <= 32'd0;
      s1_instr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      s0_valid_q <= s0_valid_d;
      s1_valid_q <= s1_valid_d;
      s0_pc_q    <= s0_pc_d;
      s1_pc_q    <= s1_pc_d;
      s0_instr_q <= s0_instr_d;
      s1_instr_q <= s1_instr_d;
    end
  end

  assign slot0_valid = s0_valid_q;
  assign slot1_valid = s1_valid_q;
  assign slot0_pc    = s0_pc_q;
  assign slot1_pc    = s1_pc_q;
  assign slot0_instr = s0_instr_q;
  assign slot1_instr = s1_instr_q;
  assign dbg_state   = state_q;

endmodule
